// File: rtl/mem_pkg.sv
// mem_bridge shared types.
// FSM encoding and byte-offset constant.
package mem_pkg;

  typedef enum logic [2:0] {
    m_idle,
    m_write,
    m_read,
    m_done,
    m_error
  } memState;

  localparam int BYTE_OFF = 2;

endpackage

// File: rtl/mem_bridge_if.sv
// Requester-side bus of mem_bridge.
// master = control unit, slave = bridge.
interface mem_bridge_if
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/mem_bridge.sv
// Multicycle databus-to-RAM access controller.
// One access at a time; bad addresses never reach the RAM.
module mem_bridge
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_bridge_if.slave       bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [2:0] LAST = 3'(RD_LAT - 1);

  memState           state;
  memState           state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic [2:0]        cnt;
  logic              accept;

  function automatic logic bad_addr(
    input logic [DATA_W-1:0] a
  );
    return (a[BYTE_OFF-1:0] != '0) ||
           (a[DATA_W-1:ADDR_W+BYTE_OFF] != '0);
  endfunction

  assign accept = (state == m_idle) && bus.req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= m_idle;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      m_idle: begin
        if (bus.req) begin
          if (bad_addr(bus.addr)) state_d = m_error;
          else if (bus.we)        state_d = m_write;
          else                    state_d = m_read;
        end
      end
      m_write: state_d = m_done;
      m_read: begin
        if (cnt == LAST) state_d = m_done;
      end
      m_done:  state_d = m_idle;
      m_error: state_d = m_idle;
      default: state_d = m_idle;
    endcase
  end

  // addr_q keeps only the word address; the rest is checked at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.addr[ADDR_W+BYTE_OFF-1:BYTE_OFF];
        wdata_q <= bus.wdata;
        we_q    <= bus.we;
        cnt     <= '0;
      end
      if (state == m_read) begin
        cnt <= cnt + 3'd1;
        if (cnt == LAST) rdata_q <= ram_dout;
      end
    end
  end

  assign ram_addr  = addr_q;
  assign ram_din   = wdata_q;
  assign ram_we    = (state == m_write) && we_q;
  assign bus.rdata = rdata_q;
  assign bus.ack   = (state == m_done) || (state == m_error);
  assign bus.err   = (state == m_error);
  assign bus.busy  = (state != m_idle);

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge.
// Three DUTs with RD_LAT 1..3 share one stimulus stream.
module tb_mem_bridge;
  import mem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int N      = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          start;
    int          ack_cyc;
  } exp_t;

  typedef struct {
    int          a;
    logic [31:0] d;
    int          cyc;
  } wexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b1;
  logic        done = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [N-1:0] busy_v;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  exp_t  exp_q [N][$];
  wexp_t wq    [N][$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : inst
    mem_bridge_if #(.DATA_W(DATA_W)) bus ();
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    logic              ram_we;
    logic [31:0]       ram [DEPTH];
    logic [31:0]       pipe [g > 0 ? g : 1];

    assign bus.req   = req;
    assign bus.we    = we;
    assign bus.addr  = addr;
    assign bus.wdata = wdata;
    assign busy_v[g] = bus.busy;

    mem_bridge #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .RD_LAT(g + 1)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_dout (ram_dout)
    );

    always @(posedge clk) begin
      if (clr) for (int k = 0; k < DEPTH; k++) ram[k] <= '0;
      else if (ram_we) ram[ram_addr] <= ram_din;
    end

    // RAM data appears RD_LAT-1 edges after ram_addr
    if (g == 0) begin : comb_rd
      assign ram_dout = ram[ram_addr];
    end else begin : pipe_rd
      always @(posedge clk) begin
        pipe[0] <= ram[ram_addr];
        for (int k = 1; k < g; k++) pipe[k] <= pipe[k-1];
      end
      assign ram_dout = pipe[g-1];
    end

    always @(negedge clk) begin
      exp_t  e;
      wexp_t x;
      logic  win;
      win = (exp_q[g].size() > 0) &&
            (cyc >= exp_q[g][0].start) &&
            (cyc <= exp_q[g][0].ack_cyc);
      check($sformatf("busy_l%0d", g + 1), bus.busy, win);
      if (bus.ack) begin
        if (exp_q[g].size() == 0) begin
          check($sformatf("spur_ack_l%0d", g + 1), bus.ack, 0);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("ack_cyc_l%0d", g + 1), cyc, e.ack_cyc);
          check($sformatf("err_l%0d", g + 1), bus.err, e.err);
          check($sformatf("rdata_l%0d", g + 1), bus.rdata, e.rdata);
        end
      end else if (exp_q[g].size() > 0 &&
                   cyc > exp_q[g][0].ack_cyc) begin
        e = exp_q[g].pop_front();
        check($sformatf("ack_late_l%0d", g + 1), bus.ack, 1);
      end
      if (ram_we) begin
        if (wq[g].size() == 0) begin
          check($sformatf("spur_we_l%0d", g + 1), ram_we, 0);
        end else begin
          x = wq[g].pop_front();
          check($sformatf("we_cyc_l%0d", g + 1), cyc, x.cyc);
          check($sformatf("we_addr_l%0d", g + 1), ram_addr, x.a);
          check($sformatf("we_din_l%0d", g + 1), ram_din, x.d);
        end
      end else if (wq[g].size() > 0 && cyc > wq[g][0].cyc) begin
        x = wq[g].pop_front();
        check($sformatf("we_miss_l%0d", g + 1), ram_we, 1);
      end
    end

    always @(negedge rst) begin
      #1;
      check($sformatf("rst_busy_l%0d", g + 1), bus.busy, 0);
      check($sformatf("rst_ack_l%0d", g + 1), bus.ack, 0);
      check($sformatf("rst_err_l%0d", g + 1), bus.err, 0);
      check($sformatf("rst_we_l%0d", g + 1), ram_we, 0);
      check($sformatf("rst_rdata_l%0d", g + 1), bus.rdata, 0);
      check($sformatf("rst_raddr_l%0d", g + 1), ram_addr, 0);
      check($sformatf("rst_rdin_l%0d", g + 1), ram_din, 0);
    end

    always @(posedge done) begin
      int bad_n;
      bad_n = 0;
      for (int k = 0; k < DEPTH; k++)
        if (ram[k] !== ref_mem[k]) bad_n++;
      check($sformatf("ram_words_l%0d", g + 1), bad_n, 0);
    end
  end

  task automatic access(input bit w, input logic [31:0] a,
                        input logic [31:0] d,
                        input bit poke, input bit abort);
    exp_t  e;
    wexp_t x;
    bit    bad;
    int    st;
    @(negedge clk);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    st = cyc + 1;
    bad = (a % 4 != 0) || (a >= 4 * DEPTH);
    if (!bad && w) ref_mem[a / 4] = d;
    if (!bad && !w) last_rd = ref_mem[a / 4];
    for (int i = 0; i < N; i++) begin
      e.err = bad;
      e.rdata = last_rd;
      e.start = st;
      e.ack_cyc = st + (bad ? 0 : (w ? 1 : i + 1));
      exp_q[i].push_back(e);
      if (!bad && w) begin
        x.a = a / 4;
        x.d = d;
        x.cyc = st;
        wq[i].push_back(x);
      end
    end
    if (abort) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        exp_q[i].delete();
        wq[i].delete();
      end
      last_rd = '0;
      rst = 1'b0;
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    @(negedge clk);
    req = poke;
    we = $urandom_range(0, 1);
    addr = $urandom;
    wdata = $urandom;
    if (poke) begin
      @(negedge clk);
      req = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_v == '0) break;
    end
    check("idle_after_access", busy_v, 0);
  endtask

  initial begin
    logic [31:0] a;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    last_rd = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    access(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
    access(0, 32'h0000_0010, 32'h0, 0, 0);
    access(0, 32'h0000_0012, 32'h0, 0, 0);
    access(1, 32'h0000_1000, 32'h1234_5678, 0, 0);
    access(0, 32'h0000_0000, 32'h0, 0, 0);
    access(1, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 0);
    access(0, 32'h0000_0FFC, 32'h0, 0, 0);
    access(0, 32'h0000_0010, 32'h0, 1, 0);
    access(0, 32'h0000_0FFC, 32'h0, 0, 1);
    access(1, 32'h0000_0020, 32'hA5A5_5A5A, 0, 0);
    access(0, 32'h0000_0020, 32'h0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0)
        a = a | (32'h1 << $urandom_range(12, 31));
      access($urandom_range(0, 1), a, $urandom,
             $urandom_range(0, 3) == 0, 0);
    end

    repeat (3) @(negedge clk);
    done = 1'b1;
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
